cp0_exc_ctrl: RTL and testbench
===============================

# cp0_exc_ctrl

Coprocessor-0 exception controller for the 5-stage MIPS pipeline. It takes the 2-bit exception code and instruction context from the MEM stage, plus hardware interrupt lines, and maintains Status, Cause and EPC. It sequences exception entry and `eret` return by issuing a one-cycle pipeline flush and PC redirect. It also serves `mfc0` and `mtc0`.

## Interface
- HANDLER_PC, 32'h0000_4180, exception/interrupt vector
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- ExcCode  in  2  MEM-stage exception code: `Int` (none), `Unimpl`, `Ov`
- mem_valid  in  1  MEM stage holds a real (non-bubble) instruction
- mem_pc  in  32  PC of the MEM-stage instruction
- mem_bd  in  1  MEM-stage instruction sits in a branch delay slot
- eret  in  1  MEM-stage instruction is `eret`
- mtc0_we  in  1  MEM-stage `mtc0` write strobe
- cp0_addr  in  5  CP0 register number for mfc0/mtc0
- cp0_wdata  in  32  mtc0 data
- hw_int  in  6  level-sensitive hardware interrupt lines
- cp0_rdata  out  32  mfc0 read data (combinational)
- flush  out  1  kill IF..MEM, one cycle
- redirect  out  1  load redirect_pc into the PC, one cycle
- redirect_pc  out  32  target PC
- exl  out  1  Status.EXL, for the hazard unit

## Operation
- Registers:
  - Status (12): IM[15:8], EXL[1], IE[0]; other bits read as 0.
  - Cause (13): BD[31], IP[15:10]=hw_int sampled each cycle, IP[9:8] software bits, ExcCode[6:2].
  - EPC (14): 32 bits.
  - Any other address reads 0; writes to it are ignored.
- Code mapping into Cause.ExcCode: `Int`→0, `Unimpl`→10, `Ov`→12.
- Events, evaluated each RUN cycle in priority order:
  1. Synchronous exception: mem_valid && ExcCode != `Int`.
  2. Interrupt: mem_valid && IE && !EXL && |(IP & IM).
  3. `eret`: mem_valid && eret.
  4. mtc0: mem_valid && mtc0_we.
- Entry (case 1 or 2), on the edge closing the cycle:
  - EPC ← mem_bd ? mem_pc−4 : mem_pc; mod 2^32, so 0 wraps to 32'hFFFF_FFFC.
  - Cause.BD ← mem_bd.
  - Cause.ExcCode ← mapped code, or 0 for an interrupt.
  - EXL ← 1.
  - FSM → FLUSH; target latch ← HANDLER_PC.
- `eret`: EXL ← 0; target latch ← EPC (value before this edge); FSM → FLUSH.
- mtc0 write rules:
  - Status: IM, EXL and IE written.
  - Cause: only IP[9:8] written.
  - EPC: written fully.
  - A lower-priority mtc0 in the same cycle as an entry or `eret` is dropped.
- Simultaneous mtc0 to EXL and an interrupt in the same cycle: the interrupt decision uses the pre-write EXL.

## Timing
- FSM states:
  - RUN: outputs idle; events evaluated.
  - FLUSH: flush=1, redirect=1, redirect_pc=target latch; no events evaluated; always → RUN after one cycle.
- Latency: event in cycle N → flush/redirect high for exactly cycle N+1. CP0 register updates are visible to cp0_rdata in cycle N+1.
- Back-to-back: an event in cycle N+1 (the FLUSH cycle) is ignored; the instruction carrying it is flushed.
- Reset values:
  - Status=0, Cause=0 (IP[15:10] resamples hw_int on the first cycle after reset), EPC=0.
  - FSM=RUN; flush=0, redirect=0, redirect_pc=0, exl=0.
- Reset asserted during FLUSH: flush and redirect are 0 on the cycle after the reset edge.
- hw_int has no synchronizer here; the lines arrive already synchronous to clk.

## Structure
- CP0 define file holds:
  - the 2-bit codes `Int`, `Unimpl`, `Ov`;
  - register numbers 12, 13, 14;
  - the 5-bit Cause codes 0, 10, 12;
  - bit positions for IE, EXL, BD, IM and IP.
- One sub-module, `cp0_regfile`: Status/Cause/EPC storage, write-port muxing and the read mux.
- The event-priority logic and the two-state FSM stay in the top module.

## Test plan
- Overflow at mem_pc=0x0040_0010, mem_bd=0 → in the next cycle, flush=redirect=1, redirect_pc=0x0000_4180, EPC=0x0040_0010, Cause.ExcCode=12, EXL=1.
- RI in a delay slot at mem_pc=0x0040_0024 → EPC=0x0040_0020, BD=1, ExcCode=10.
- mtc0 Status=0x0000_0401, then hw_int[0]=1 → interrupt taken, ExcCode=0. With EXL=1 or IE=0, no interrupt is taken.
- Ov and hw_int pending in the same cycle → ExcCode=12 (exception wins). An event in the FLUSH cycle is ignored; flush stays high exactly one cycle.
- `eret` with EPC=0x0040_0010 → redirect_pc=0x0040_0010 next cycle, EXL=0, then mfc0 of reg 12 returns 0x0000_0401.
- rst asserted during FLUSH → flush=redirect=0 next cycle, and mfc0 of regs 12, 13 and 14 reads 0, except Cause IP[15:10], which reflects hw_int.

Source files
------------

// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared CP0 definitions: MEM-stage exception codes, register numbers,
// Cause.ExcCode values and the bit layout of Status/Cause.
package cp0_exc_ctrl_pkg;

    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

    typedef enum logic [1:0] {
        EXC_INT    = 2'd0,
        EXC_UNIMPL = 2'd1,
        EXC_OV     = 2'd2
    } exc_code_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    localparam logic [4:0] REG_STATUS = 5'd12;
    localparam logic [4:0] REG_CAUSE  = 5'd13;
    localparam logic [4:0] REG_EPC    = 5'd14;

    localparam logic [4:0] CAUSE_CODE_INT = 5'd0;
    localparam logic [4:0] CAUSE_CODE_RI  = 5'd10;
    localparam logic [4:0] CAUSE_CODE_OV  = 5'd12;

    localparam int STATUS_IE_BIT  = 0;
    localparam int STATUS_EXL_BIT = 1;
    localparam int STATUS_IM_LSB  = 8;
    localparam int CAUSE_BD_BIT   = 31;
    localparam int CAUSE_IP_LSB   = 8;
    localparam int CAUSE_IPHW_LSB = 10;
    localparam int CAUSE_EXC_LSB  = 2;

    localparam logic [31:0] STATUS_WMASK   = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_SW_MASK  = 32'h0000_0300;
    localparam logic [31:0] CAUSE_BD_MASK  = 32'h8000_0000;
    localparam logic [31:0] CAUSE_EXC_MASK = 32'h0000_007C;

    // Code 2'b11 is not produced by the decoder; treat it like an unimplemented op.
    function automatic logic [4:0] map_exc_code(input logic [1:0] code);
        case (code)
            EXC_INT:    map_exc_code = CAUSE_CODE_INT;
            EXC_OV:     map_exc_code = CAUSE_CODE_OV;
            default:    map_exc_code = CAUSE_CODE_RI;
        endcase
    endfunction

endpackage

// File: rtl/cp0_exc_ctrl_regfile.sv
// Status/Cause/EPC storage with a single prioritised write port
// (entry > eret > mtc0) and the combinational mfc0 read mux.
module cp0_regfile
    import cp0_exc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  hw_int,
    input  logic        entry_en,
    input  logic        entry_bd,
    input  logic [31:0] entry_epc,
    input  logic [4:0]  entry_code,
    input  logic        eret_en,
    input  logic        mtc0_en,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] epc,
    output logic        status_ie,
    output logic        status_exl,
    output logic        irq_pending
);

    logic [31:0] status_q;
    logic [31:0] cause_q;
    logic [5:0]  ip_hw_q;
    logic [31:0] epc_q;
    logic [31:0] cause_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q <= 32'd0;
            cause_q  <= 32'd0;
            ip_hw_q  <= 6'd0;
            epc_q    <= 32'd0;
        end else begin
            ip_hw_q <= hw_int;
            if (entry_en) begin
                epc_q    <= entry_epc;
                status_q <= status_q | (32'd1 << STATUS_EXL_BIT);
                cause_q  <= (cause_q & ~(CAUSE_BD_MASK | CAUSE_EXC_MASK))
                          | ({31'd0, entry_bd} << CAUSE_BD_BIT)
                          | ({27'd0, entry_code} << CAUSE_EXC_LSB);
            end else if (eret_en) begin
                status_q <= status_q & ~(32'd1 << STATUS_EXL_BIT);
            end else if (mtc0_en) begin
                case (addr)
                    REG_STATUS: status_q <= wdata & STATUS_WMASK;
                    REG_CAUSE:  cause_q  <= (cause_q & ~CAUSE_SW_MASK) | (wdata & CAUSE_SW_MASK);
                    REG_EPC:    epc_q    <= wdata;
                    default:    ;
                endcase
            end
        end
    end

    assign cause_rd = cause_q | ({26'd0, ip_hw_q} << CAUSE_IPHW_LSB);

    always_comb begin
        rdata = 32'd0;
        case (addr)
            REG_STATUS: rdata = status_q;
            REG_CAUSE:  rdata = cause_rd;
            REG_EPC:    rdata = epc_q;
            default:    rdata = 32'd0;
        endcase
    end

    assign epc         = epc_q;
    assign status_ie   = status_q[STATUS_IE_BIT];
    assign status_exl  = status_q[STATUS_EXL_BIT];
    assign irq_pending = |(cause_rd[CAUSE_IP_LSB +: 8] & status_q[STATUS_IM_LSB +: 8]);

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception controller: prioritises MEM-stage events, then spends one
// FLUSH cycle killing the pipeline and redirecting the PC.
module cp0_exc_ctrl
    import cp0_exc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  ExcCode,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic        mem_bd,
    input  logic        eret,
    input  logic        mtc0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    input  logic [5:0]  hw_int,
    output logic [31:0] cp0_rdata,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        exl,
    output state_e      dbg_state
);

    state_e      state_q, state_d;
    logic [31:0] target_q, target_d;

    logic        in_run;
    logic        sync_exc;
    logic        irq;
    logic        take_entry;
    logic        do_eret;
    logic        do_mtc0;
    logic [31:0] entry_epc;
    logic [4:0]  entry_code;
    logic [31:0] epc;
    logic        status_ie;
    logic        status_exl;
    logic        irq_pending;

    // Interrupt gating uses the pre-edge Status, so a same-cycle mtc0 cannot unmask itself.
    assign in_run     = (state_q == ST_RUN);
    assign sync_exc   = in_run && mem_valid && (ExcCode != EXC_INT);
    assign irq        = in_run && mem_valid && status_ie && !status_exl && irq_pending;
    assign take_entry = sync_exc || irq;
    assign do_eret    = in_run && mem_valid && eret && !take_entry;
    assign do_mtc0    = in_run && mem_valid && mtc0_we && !take_entry && !do_eret;
    assign entry_epc  = mem_bd ? (mem_pc - 32'd4) : mem_pc;
    assign entry_code = sync_exc ? map_exc_code(ExcCode) : CAUSE_CODE_INT;

    cp0_regfile u_regfile (
        .clk         (clk),
        .rst         (rst),
        .hw_int      (hw_int),
        .entry_en    (take_entry),
        .entry_bd    (mem_bd),
        .entry_epc   (entry_epc),
        .entry_code  (entry_code),
        .eret_en     (do_eret),
        .mtc0_en     (do_mtc0),
        .addr        (cp0_addr),
        .wdata       (cp0_wdata),
        .rdata       (cp0_rdata),
        .epc         (epc),
        .status_ie   (status_ie),
        .status_exl  (status_exl),
        .irq_pending (irq_pending)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            target_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        flush       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        case (state_q)
            ST_RUN: begin
                if (take_entry) begin
                    state_d  = ST_FLUSH;
                    target_d = HANDLER_PC;
                end else if (do_eret) begin
                    state_d  = ST_FLUSH;
                    target_d = epc;
                end
            end
            ST_FLUSH: begin
                flush       = 1'b1;
                redirect    = 1'b1;
                redirect_pc = target_q;
                state_d     = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign exl       = status_exl;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed bench for cp0_exc_ctrl: each task drives one scenario and
// compares outputs and mfc0 reads against hand-computed values.
module tb_cp0_exc_ctrl;
    import cp0_exc_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic [1:0]  ExcCode;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        mem_bd;
    logic        eret;
    logic        mtc0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [5:0]  hw_int;
    logic [31:0] cp0_rdata;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        exl;
    state_e      dbg_state;

    int checks;
    int failures;

    cp0_exc_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .ExcCode     (ExcCode),
        .mem_valid   (mem_valid),
        .mem_pc      (mem_pc),
        .mem_bd      (mem_bd),
        .eret        (eret),
        .mtc0_we     (mtc0_we),
        .cp0_addr    (cp0_addr),
        .cp0_wdata   (cp0_wdata),
        .hw_int      (hw_int),
        .cp0_rdata   (cp0_rdata),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .exl         (exl),
        .dbg_state   (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        mem_valid = 1'b0;
        ExcCode   = EXC_INT;
        mem_pc    = 32'd0;
        mem_bd    = 1'b0;
        eret      = 1'b0;
        mtc0_we   = 1'b0;
        cp0_wdata = 32'd0;
    endtask

    task automatic drive_mtc0(input logic [4:0] a, input logic [31:0] d);
        drive_idle();
        mem_valid = 1'b1;
        mtc0_we   = 1'b1;
        cp0_addr  = a;
        cp0_wdata = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; hw_int = 6'd0; cp0_addr = 5'd0; drive_idle();
        step(); step();
        rst = 1'b0;
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL rst_flush got=%0h exp=0", flush); end
        checks++; if (redirect !== 1'b0) begin failures++; $display("FAIL rst_redirect got=%0h exp=0", redirect); end
        checks++; if (redirect_pc !== 32'd0) begin failures++; $display("FAIL rst_redirect_pc got=%08h exp=0", redirect_pc); end
        checks++; if (exl !== 1'b0) begin failures++; $display("FAIL rst_exl got=%0h exp=0", exl); end
        cp0_addr = REG_STATUS; #1;
        checks++; if (cp0_rdata !== 32'd0) begin failures++; $display("FAIL rst_status got=%08h exp=0", cp0_rdata); end
        cp0_addr = REG_CAUSE; #1;
        checks++; if (cp0_rdata !== 32'd0) begin failures++; $display("FAIL rst_cause got=%08h exp=0", cp0_rdata); end
        cp0_addr = REG_EPC; #1;
        checks++; if (cp0_rdata !== 32'd0) begin failures++; $display("FAIL rst_epc got=%08h exp=0", cp0_rdata); end
    endtask

    task automatic test_overflow();
        drive_idle(); mem_valid = 1'b1; ExcCode = EXC_OV; mem_pc = 32'h0040_0010;
        step();
        drive_idle();
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL ov_flush got=%0h exp=1", flush); end
        checks++; if (redirect !== 1'b1) begin failures++; $display("FAIL ov_redirect got=%0h exp=1", redirect); end
        checks++; if (redirect_pc !== 32'h0000_4180) begin failures++; $display("FAIL ov_redirect_pc got=%08h exp=00004180", redirect_pc); end
        checks++; if (exl !== 1'b1) begin failures++; $display("FAIL ov_exl got=%0h exp=1", exl); end
        cp0_addr = REG_EPC; #1;
        checks++; if (cp0_rdata !== 32'h0040_0010) begin failures++; $display("FAIL ov_epc got=%08h exp=00400010", cp0_rdata); end
        cp0_addr = REG_CAUSE; #1;
        checks++; if (cp0_rdata !== 32'h0000_0030) begin failures++; $display("FAIL ov_cause got=%08h exp=00000030", cp0_rdata); end
        cp0_addr = REG_STATUS; #1;
        checks++; if (cp0_rdata !== 32'h0000_0002) begin failures++; $display("FAIL ov_status got=%08h exp=00000002", cp0_rdata); end
        step();
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL ov_flush_one_cycle got=%0h exp=0", flush); end
    endtask

    task automatic test_ri_delay_slot();
        drive_idle(); mem_valid = 1'b1; ExcCode = EXC_UNIMPL; mem_pc = 32'h0040_0024; mem_bd = 1'b1;
        step();
        drive_idle();
        cp0_addr = REG_EPC; #1;
        checks++; if (cp0_rdata !== 32'h0040_0020) begin failures++; $display("FAIL ri_epc got=%08h exp=00400020", cp0_rdata); end
        cp0_addr = REG_CAUSE; #1;
        checks++; if (cp0_rdata !== 32'h8000_0028) begin failures++; $display("FAIL ri_cause got=%08h exp=80000028", cp0_rdata); end
        step();
        drive_idle(); mem_valid = 1'b1; ExcCode = EXC_OV; mem_pc = 32'd0; mem_bd = 1'b1;
        step();
        drive_idle();
        cp0_addr = REG_EPC; #1;
        checks++; if (cp0_rdata !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_epc got=%08h exp=fffffffc", cp0_rdata); end
        cp0_addr = REG_CAUSE; #1;
        checks++; if (cp0_rdata !== 32'h8000_0030) begin failures++; $display("FAIL wrap_cause got=%08h exp=80000030", cp0_rdata); end
        step();
    endtask

    task automatic test_interrupt();
        hw_int = 6'b000001;
        drive_mtc0(REG_STATUS, 32'h0000_0403);
        step();
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL irq_setup_flush got=%0h exp=0", flush); end
        drive_mtc0(REG_STATUS, 32'h0000_0401);
        step();
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL irq_pre_exl_flush got=%0h exp=0", flush); end
        drive_idle();
        cp0_addr = REG_CAUSE; #1;
        checks++; if (cp0_rdata !== 32'h8000_0430) begin failures++; $display("FAIL irq_cause_ip got=%08h exp=80000430", cp0_rdata); end
        mem_valid = 1'b1; mem_pc = 32'h0040_0100;
        step();
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL irq_flush got=%0h exp=1", flush); end
        checks++; if (redirect_pc !== 32'h0000_4180) begin failures++; $display("FAIL irq_redirect_pc got=%08h exp=00004180", redirect_pc); end
        cp0_addr = REG_CAUSE; #1;
        checks++; if (cp0_rdata !== 32'h0000_0400) begin failures++; $display("FAIL irq_cause got=%08h exp=00000400", cp0_rdata); end
        cp0_addr = REG_EPC; #1;
        checks++; if (cp0_rdata !== 32'h0040_0100) begin failures++; $display("FAIL irq_epc got=%08h exp=00400100", cp0_rdata); end
        ExcCode = EXC_OV; mem_pc = 32'h0040_0200;
        step();
        drive_idle();
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL b2b_flush got=%0h exp=0", flush); end
        cp0_addr = REG_EPC; #1;
        checks++; if (cp0_rdata !== 32'h0040_0100) begin failures++; $display("FAIL b2b_epc got=%08h exp=00400100", cp0_rdata); end
        mem_valid = 1'b1;
        step();
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL irq_exl_block got=%0h exp=0", flush); end
        drive_mtc0(REG_STATUS, 32'h0000_0400);
        step();
        drive_idle(); mem_valid = 1'b1;
        step();
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL irq_ie_block got=%0h exp=0", flush); end
        cp0_addr = REG_STATUS; #1;
        checks++; if (cp0_rdata !== 32'h0000_0400) begin failures++; $display("FAIL irq_ie_status got=%08h exp=00000400", cp0_rdata); end
    endtask

    task automatic test_priority();
        drive_mtc0(REG_STATUS, 32'h0000_0401);
        step();
        drive_idle(); mem_valid = 1'b1; ExcCode = EXC_OV; mem_pc = 32'h0040_0300;
        step();
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL prio_flush got=%0h exp=1", flush); end
        cp0_addr = REG_CAUSE; #1;
        checks++; if (cp0_rdata !== 32'h0000_0430) begin failures++; $display("FAIL prio_cause got=%08h exp=00000430", cp0_rdata); end
        drive_idle(); mem_valid = 1'b1; eret = 1'b1;
        step();
        drive_idle();
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL prio_b2b_flush got=%0h exp=0", flush); end
        checks++; if (exl !== 1'b1) begin failures++; $display("FAIL prio_b2b_exl got=%0h exp=1", exl); end
    endtask

    task automatic test_eret();
        hw_int = 6'd0;
        drive_mtc0(REG_EPC, 32'h0040_0010);
        step();
        drive_idle();
        cp0_addr = REG_EPC; #1;
        checks++; if (cp0_rdata !== 32'h0040_0010) begin failures++; $display("FAIL eret_epc_wr got=%08h exp=00400010", cp0_rdata); end
        drive_mtc0(REG_STATUS, 32'd0); eret = 1'b1;
        step();
        drive_idle();
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL eret_flush got=%0h exp=1", flush); end
        checks++; if (redirect_pc !== 32'h0040_0010) begin failures++; $display("FAIL eret_redirect_pc got=%08h exp=00400010", redirect_pc); end
        checks++; if (exl !== 1'b0) begin failures++; $display("FAIL eret_exl got=%0h exp=0", exl); end
        cp0_addr = REG_STATUS; #1;
        checks++; if (cp0_rdata !== 32'h0000_0401) begin failures++; $display("FAIL eret_status got=%08h exp=00000401", cp0_rdata); end
        step();
        checks++; if (redirect !== 1'b0) begin failures++; $display("FAIL eret_redirect_end got=%0h exp=0", redirect); end
    endtask

    task automatic test_mtc0_masks();
        drive_mtc0(REG_CAUSE, 32'hFFFF_FFFF);
        step();
        drive_idle();
        cp0_addr = REG_CAUSE; #1;
        checks++; if (cp0_rdata !== 32'h0000_0330) begin failures++; $display("FAIL mtc0_cause got=%08h exp=00000330", cp0_rdata); end
        drive_mtc0(REG_STATUS, 32'hFFFF_FFFF);
        step();
        drive_idle();
        cp0_addr = REG_STATUS; #1;
        checks++; if (cp0_rdata !== 32'h0000_FF03) begin failures++; $display("FAIL mtc0_status got=%08h exp=0000ff03", cp0_rdata); end
        drive_mtc0(5'd5, 32'hFFFF_FFFF);
        step();
        drive_idle();
        cp0_addr = 5'd5; #1;
        checks++; if (cp0_rdata !== 32'd0) begin failures++; $display("FAIL mtc0_unmapped got=%08h exp=0", cp0_rdata); end
        cp0_addr = REG_STATUS; #1;
        checks++; if (cp0_rdata !== 32'h0000_FF03) begin failures++; $display("FAIL mtc0_unmapped_status got=%08h exp=0000ff03", cp0_rdata); end
    endtask

    task automatic test_reset_in_flush();
        drive_idle(); mem_valid = 1'b1; ExcCode = EXC_OV; mem_pc = 32'h0040_0400;
        step();
        checks++; if (flush !== 1'b1) begin failures++; $display("FAIL rstf_pre_flush got=%0h exp=1", flush); end
        drive_idle(); rst = 1'b1; hw_int = 6'b100001;
        step();
        rst = 1'b0;
        checks++; if (flush !== 1'b0) begin failures++; $display("FAIL rstf_flush got=%0h exp=0", flush); end
        checks++; if (redirect !== 1'b0) begin failures++; $display("FAIL rstf_redirect got=%0h exp=0", redirect); end
        checks++; if (exl !== 1'b0) begin failures++; $display("FAIL rstf_exl got=%0h exp=0", exl); end
        cp0_addr = REG_STATUS; #1;
        checks++; if (cp0_rdata !== 32'd0) begin failures++; $display("FAIL rstf_status got=%08h exp=0", cp0_rdata); end
        cp0_addr = REG_EPC; #1;
        checks++; if (cp0_rdata !== 32'd0) begin failures++; $display("FAIL rstf_epc got=%08h exp=0", cp0_rdata); end
        step();
        cp0_addr = REG_CAUSE; #1;
        checks++; if (cp0_rdata !== 32'h0000_8400) begin failures++; $display("FAIL rstf_cause_ip got=%08h exp=00008400", cp0_rdata); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_overflow();
        test_ri_delay_slot();
        test_interrupt();
        test_priority();
        test_eret();
        test_mtc0_masks();
        test_reset_in_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
